// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported instruction/data memory between
// the IF (fetch) and MEM (data) pipeline stages over a req/ready handshake.
// Data requests win over fetches; each access runs IDLE -> BUSY_x -> DONE.
// A watchdog aborts accesses that wait TIMEOUT cycles (TIMEOUT=0 disables it).
//
// Ports:
//   clk, reset                    clock (rising edge), async active-low reset
//   if_req/if_addr/if_flush       fetch request, address, squash
//   if_rdata/if_done              fetched word and one-cycle completion pulse
//   d_req/d_we/d_addr/d_wdata     data request (load/store)
//   d_rdata/d_done                load data and one-cycle completion pulse
//   stall_f/stall_m               combinational stall requests to hazard unit
//   mem_req/mem_we/mem_addr/mem_wdata   registered memory request
//   mem_rdata/mem_ready           memory response
//   err                           sticky timeout flag
module mem_port_arbiter #(
    parameter int unsigned AW      = 32,
    parameter int unsigned DW      = 32,
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CW      = 5
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    input  logic          if_flush,
    output logic [DW-1:0] if_rdata,
    output logic          if_done,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic [DW-1:0] d_rdata,
    output logic          d_done,
    output logic          stall_f,
    output logic          stall_m,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ready,
    output logic          err
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_D = 2'd1,
        BUSY_I = 2'd2,
        DONE   = 2'd3
    } arbStateT;

    arbStateT      state, stateNext;
    logic [CW-1:0] cnt, cntNext;
    logic          squash, squashNext;
    logic          memReqNext, memWeNext;
    logic [AW-1:0] memAddrNext;
    logic [DW-1:0] memWdataNext;
    logic [DW-1:0] ifRdataNext, dRdataNext;
    logic          ifDoneNext, dDoneNext;
    logic          errNext;
    logic          timeoutHit;
    logic          fetchKilled;

    // Stall requests follow the live request inputs.
    assign stall_f = if_req & ~if_done & ~if_flush;
    assign stall_m = d_req & ~d_done;

    // Watchdog fires on the waiting cycle that brings the count to TIMEOUT.
    assign timeoutHit = (TIMEOUT != 0) && !mem_ready &&
                        ((CW+1)'(cnt) + (CW+1)'(1) == (CW+1)'(TIMEOUT));

    // A flush seen earlier or in the completing cycle kills the fetch result.
    assign fetchKilled = squash | if_flush;

    // Next-state and next-output logic.
    always_comb begin
        stateNext    = state;
        cntNext      = cnt;
        squashNext   = squash;
        memReqNext   = mem_req;
        memWeNext    = mem_we;
        memAddrNext  = mem_addr;
        memWdataNext = mem_wdata;
        ifRdataNext  = if_rdata;
        dRdataNext   = d_rdata;
        ifDoneNext   = 1'b0;
        dDoneNext    = 1'b0;
        errNext      = err;

        case (state)
            IDLE: begin
                if (d_req) begin
                    memReqNext   = 1'b1;
                    memWeNext    = d_we;
                    memAddrNext  = d_addr;
                    memWdataNext = d_wdata;
                    cntNext      = '0;
                    squashNext   = 1'b0;
                    stateNext    = BUSY_D;
                end else if (if_req && !if_flush) begin
                    memReqNext  = 1'b1;
                    memWeNext   = 1'b0;
                    memAddrNext = if_addr;
                    cntNext     = '0;
                    squashNext  = 1'b0;
                    stateNext   = BUSY_I;
                end
            end

            BUSY_D: begin
                if (!mem_ready) begin
                    cntNext = cnt + CW'(1);
                end
                if (mem_ready) begin
                    memReqNext = 1'b0;
                    memWeNext  = 1'b0;
                    if (!mem_we) begin
                        dRdataNext = mem_rdata;
                    end
                    dDoneNext = 1'b1;
                    stateNext = DONE;
                end else if (timeoutHit) begin
                    memReqNext = 1'b0;
                    memWeNext  = 1'b0;
                    errNext    = 1'b1;
                    dRdataNext = '0;
                    dDoneNext  = 1'b1;
                    stateNext  = DONE;
                end
            end

            BUSY_I: begin
                if (!mem_ready) begin
                    cntNext = cnt + CW'(1);
                end
                if (if_flush) begin
                    squashNext = 1'b1;
                end
                if (mem_ready) begin
                    memReqNext = 1'b0;
                    memWeNext  = 1'b0;
                    if (!fetchKilled) begin
                        ifRdataNext = mem_rdata;
                        ifDoneNext  = 1'b1;
                    end
                    stateNext = DONE;
                end else if (timeoutHit) begin
                    memReqNext = 1'b0;
                    memWeNext  = 1'b0;
                    errNext    = 1'b1;
                    if (!fetchKilled) begin
                        ifRdataNext = '0;
                        ifDoneNext  = 1'b1;
                    end
                    stateNext = DONE;
                end
            end

            DONE: begin
                // Done pulse is visible this cycle; no grant until back in IDLE.
                stateNext = IDLE;
            end

            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= '0;
            squash    <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_rdata  <= '0;
            d_rdata   <= '0;
            if_done   <= 1'b0;
            d_done    <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= stateNext;
            cnt       <= cntNext;
            squash    <= squashNext;
            mem_req   <= memReqNext;
            mem_we    <= memWeNext;
            mem_addr  <= memAddrNext;
            mem_wdata <= memWdataNext;
            if_rdata  <= ifRdataNext;
            d_rdata   <= dRdataNext;
            if_done   <= ifDoneNext;
            d_done    <= dDoneNext;
            err       <= errNext;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: directed scenarios followed by randomized
// accesses, checked against a transaction-level model (golden memory,
// expected completion latency, sticky error, result registers).
module tb_mem_port_arbiter;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int          TO = 4;
    localparam int unsigned CW = 5;

    logic          clk = 1'b0;
    logic          reset;
    logic          if_req, if_flush;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          if_done;
    logic          d_req, d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata, d_rdata;
    logic          d_done;
    logic          stall_f, stall_m;
    logic          mem_req, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ready;
    logic          err;

    always #5 clk = ~clk;

    mem_port_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TO), .CW(CW)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
        .if_rdata(if_rdata), .if_done(if_done),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_done(d_done),
        .stall_f(stall_f), .stall_m(stall_m),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .err(err)
    );

    int checks = 0;
    int errors = 0;

    logic [31:0] respMem [64];
    logic [31:0] goldMem [64];
    int          delayQ [$];
    int          startCount = 0;
    int          waitLeft = 0;
    bit          inFlight = 1'b0;

    logic [31:0] expIfRdata = '0;
    logic [31:0] expDRdata  = '0;
    bit          expErr     = 1'b0;

    // Memory responder: each new request takes the next queued wait count.
    always @(negedge clk) begin
        if (!mem_req) begin
            inFlight  = 1'b0;
            mem_ready = 1'b0;
        end else begin
            if (!inFlight) begin
                inFlight = 1'b1;
                startCount++;
                waitLeft = (delayQ.size() > 0) ? delayQ.pop_front() : 0;
            end
            if (waitLeft == 0) begin
                mem_ready = 1'b1;
                if (mem_we) respMem[mem_addr[7:2]] = mem_wdata;
                else        mem_rdata = respMem[mem_addr[7:2]];
            end else begin
                mem_ready = 1'b0;
                mem_rdata = $urandom;
                waitLeft--;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One access: kind 0=load, 1=store, 2=fetch. flushAt=k flushes the fetch
    // in the cycle after the k-th clock edge (0 = no flush).
    task automatic runAccess(input int kind, input logic [31:0] addr,
                             input logic [31:0] wdata, input int delay, input int flushAt);
        bit timedOut = (delay >= TO);
        int lat      = timedOut ? TO + 1 : delay + 2;
        bit squash   = (kind == 2) && (flushAt != 0);
        int s0       = startCount;

        delayQ.push_back(delay);
        if (kind == 2) begin
            if_addr = addr; if_req = 1'b1;
        end else begin
            d_addr = addr; d_we = (kind == 1); d_wdata = wdata; d_req = 1'b1;
        end

        if (timedOut) expErr = 1'b1;
        if (kind == 0) expDRdata = timedOut ? 32'h0 : goldMem[addr[7:2]];
        else if (kind == 1) begin
            if (timedOut) expDRdata = 32'h0;
            else goldMem[addr[7:2]] = wdata;
        end else if (!squash) expIfRdata = timedOut ? 32'h0 : goldMem[addr[7:2]];

        #1;
        chk("stall_at_request", 32'((kind == 2) ? stall_f : stall_m), 32'(1));

        for (int k = 1; k <= lat + 2; k++) begin
            @(negedge clk);
            if (k < lat) begin
                chk("mem_req_busy", 32'(mem_req), 32'(1));
                chk("mem_addr", mem_addr, addr);
                chk("mem_we", 32'(mem_we), 32'(kind == 1));
                if (kind == 1) chk("mem_wdata", mem_wdata, wdata);
                if (!squash) chk("stall_busy", 32'((kind == 2) ? stall_f : stall_m), 32'(1));
            end else begin
                chk("mem_req_released", 32'(mem_req), 32'(0));
            end
            chk("if_done", 32'(if_done), 32'((kind == 2) && !squash && (k == lat)));
            chk("d_done", 32'(d_done), 32'((kind != 2) && (k == lat)));
            if (k == lat) begin
                chk("if_rdata", if_rdata, expIfRdata);
                chk("d_rdata", d_rdata, expDRdata);
                chk("err", 32'(err), 32'(expErr));
                if (!squash) chk("stall_at_done", 32'((kind == 2) ? stall_f : stall_m), 32'(0));
                if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
            end
            if_flush = (k == flushAt);
            if (k == flushAt) if_req = 1'b0;
        end
        chk("one_mem_access", 32'(startCount - s0), 32'(1));
    endtask

    initial begin
        logic [31:0] a, w;
        int kind, dly, fl, lat, s0;

        reset = 1'b0; if_req = 1'b0; if_flush = 1'b0; if_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
        mem_rdata = '0; mem_ready = 1'b0;
        for (int i = 0; i < 64; i++) begin
            w = $urandom;
            respMem[i] = w; goldMem[i] = w;
        end
        respMem[6'h10] = 32'h2002_0005; goldMem[6'h10] = 32'h2002_0005;

        // Reset values.
        repeat (3) @(negedge clk);
        chk("rst_mem_req", 32'(mem_req), 32'(0));
        chk("rst_err", 32'(err), 32'(0));
        chk("rst_if_done", 32'(if_done), 32'(0));
        chk("rst_d_done", 32'(d_done), 32'(0));
        chk("rst_if_rdata", if_rdata, 32'h0);
        chk("rst_d_rdata", d_rdata, 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        reset = 1'b1;
        @(negedge clk);

        // Basic fetch, ready after two wait cycles.
        runAccess(2, 32'h40, 32'h0, 2, 0);

        // Simultaneous fetch and load: data first, fetch next.
        delayQ.push_back(1); delayQ.push_back(0);
        s0 = startCount;
        if_addr = 32'h44; if_req = 1'b1;
        d_addr = 32'h80; d_we = 1'b0; d_req = 1'b1;
        expDRdata = goldMem[6'h20];
        expIfRdata = goldMem[6'h11];
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            chk("both_d_done", 32'(d_done), 32'(k == 3));
            chk("both_if_done", 32'(if_done), 32'(k == 6));
            chk("both_stall_f", 32'(stall_f), 32'(if_req && k < 6));
            if (k == 3) begin
                chk("both_d_rdata", d_rdata, expDRdata);
                d_req = 1'b0;
            end
            if (k == 5) begin
                chk("both_fetch_req", 32'(mem_req), 32'(1));
                chk("both_fetch_addr", mem_addr, 32'h44);
            end
            if (k == 6) begin
                chk("both_if_rdata", if_rdata, expIfRdata);
                if_req = 1'b0;
            end
        end
        chk("both_two_accesses", 32'(startCount - s0), 32'(2));

        // Store then read back.
        runAccess(1, 32'h54, 32'h7, 3, 0);
        runAccess(0, 32'h54, 32'h0, 1, 0);

        // Fetch squashed mid-access and in the completing cycle.
        runAccess(2, 32'h48, 32'h0, 2, 1);
        runAccess(2, 32'h4c, 32'h0, 2, 3);

        // Flush in IDLE blocks the grant for one cycle only.
        delayQ.push_back(0);
        s0 = startCount;
        if_addr = 32'h50; if_req = 1'b1; if_flush = 1'b1;
        expIfRdata = goldMem[6'h14];
        @(negedge clk);
        chk("idle_flush_no_grant", 32'(mem_req), 32'(0));
        if_flush = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            chk("idle_flush_if_done", 32'(if_done), 32'(k == 2));
            if (k == 2) begin
                chk("idle_flush_rdata", if_rdata, expIfRdata);
                if_req = 1'b0;
            end
        end
        chk("idle_flush_one_access", 32'(startCount - s0), 32'(1));

        // Timeout on a load; err stays set afterwards.
        runAccess(0, 32'h60, 32'h0, 9, 0);
        runAccess(2, 32'h40, 32'h0, 0, 0);

        // Randomized mix of loads, stores, fetches, squashes and timeouts.
        for (int n = 0; n < 40; n++) begin
            kind = int'($urandom_range(0, 2));
            a    = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
            w    = $urandom;
            dly  = int'($urandom_range(0, 5));
            lat  = (dly >= TO) ? TO + 1 : dly + 2;
            fl   = 0;
            if (kind == 2 && $urandom_range(0, 3) == 0)
                fl = int'($urandom_range(1, 32'(lat - 1)));
            runAccess(kind, a, w, dly, fl);
        end

        // Reset in the middle of a data access.
        delayQ.push_back(3);
        d_addr = 32'h84; d_we = 1'b0; d_req = 1'b1;
        @(negedge clk);
        chk("mid_busy_mem_req", 32'(mem_req), 32'(1));
        reset = 1'b0;
        #1;
        chk("async_rst_mem_req", 32'(mem_req), 32'(0));
        chk("async_rst_err", 32'(err), 32'(0));
        chk("async_rst_d_done", 32'(d_done), 32'(0));
        d_req = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("post_rst_idle", 32'(mem_req), 32'(0));
            chk("post_rst_no_done", 32'(d_done | if_done), 32'(0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
